// File: rtl/fp_add_sub.sv
// Seven-stage IEEE-754 single-precision add/subtract, round-to-nearest-even, denormals flushed to zero.
// Define FPADDSUB_PIPE_DEBUG_EN to export stage registers on pipe_0..pipe_5 (otherwise tied to 0).
module fp_add_sub (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  A,
  input  logic [31:0]  B,
  input  logic [2:0]   Ctrl,
  output logic [31:0]  Z,
  output logic [4:0]   Flags,
  output logic [66:0]  pipe_0,
  output logic [100:0] pipe_1,
  output logic [95:0]  pipe_2,
  output logic [75:0]  pipe_3,
  output logic [74:0]  pipe_4,
  output logic [71:0]  pipe_5,
  output logic [36:0]  pipe_6
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  function automatic logic [24:0] rne(input logic [26:0] m);
    logic inc;
    inc = m[2] & (m[3] | m[1] | m[0]);
    return {1'b0, m[26:3]} + {24'b0, inc};
  endfunction

  // Final result selection; flags are {invalid, overflow, underflow, inexact, zero}.
  function automatic logic [36:0] resolve(input logic vld, input logic nan, input logic inf,
                                          input logic zero, input logic sgn,
                                          input logic signed [9:0] e, input logic [22:0] frc,
                                          input logic inex);
    if (!vld)                 return 37'd0;
    else if (nan)             return {5'b10000, 32'h7FC00000};
    else if (inf)             return {5'b00000, sgn, 8'hFF, 23'd0};
    else if (zero)            return {5'b00001, 32'd0};
    else if (e >= 10'sd255)   return {5'b01010, sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)     return {5'b00111, sgn, 31'd0};
    else                      return {3'b000, inex, 1'b0, sgn, e[7:0], frc};
  endfunction

  // ---- Stage 0: input capture
  logic [31:0] r_a_p0, r_b_p0;
  logic [2:0]  r_ctrl_p0;
  logic        r_vld_p0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_p0 <= '0; r_b_p0 <= '0; r_ctrl_p0 <= '0; r_vld_p0 <= 1'b0;
    end else begin
      r_a_p0 <= A; r_b_p0 <= B; r_ctrl_p0 <= Ctrl; r_vld_p0 <= 1'b1;
    end
  end

  logic w_unused;
  assign w_unused = ^r_ctrl_p0[2:1];

  // ---- Stage 1: pre-align (effective sign, swap, exponent difference, specials)
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_sa, w_sb, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_a_big;
  assign w_ea    = r_a_p0[30:23];
  assign w_eb    = r_b_p0[30:23];
  assign w_fa    = (w_ea == 8'd0) ? 23'd0 : r_a_p0[22:0];
  assign w_fb    = (w_eb == 8'd0) ? 23'd0 : r_b_p0[22:0];
  assign w_sa    = r_a_p0[31];
  assign w_sb    = r_b_p0[31] ^ r_ctrl_p0[0];
  assign w_nan_a = (w_ea == 8'hFF) && (r_a_p0[22:0] != 23'd0);
  assign w_nan_b = (w_eb == 8'hFF) && (r_b_p0[22:0] != 23'd0);
  assign w_inf_a = (w_ea == 8'hFF) && (r_a_p0[22:0] == 23'd0);
  assign w_inf_b = (w_eb == 8'hFF) && (r_b_p0[22:0] == 23'd0);
  assign w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};

  logic        r_sgn_p1, r_sub_p1, r_nan_p1, r_inf_p1, r_vld_p1;
  logic [7:0]  r_exp_l_p1, r_exp_s_p1, r_diff_p1;
  logic [22:0] r_frc_l_p1, r_frc_s_p1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn_p1 <= 1'b0; r_sub_p1 <= 1'b0; r_nan_p1 <= 1'b0; r_inf_p1 <= 1'b0; r_vld_p1 <= 1'b0;
      r_exp_l_p1 <= '0; r_exp_s_p1 <= '0; r_diff_p1 <= '0; r_frc_l_p1 <= '0; r_frc_s_p1 <= '0;
    end else begin
      r_sgn_p1   <= w_a_big ? w_sa : w_sb;
      r_exp_l_p1 <= w_a_big ? w_ea : w_eb;
      r_frc_l_p1 <= w_a_big ? w_fa : w_fb;
      r_exp_s_p1 <= w_a_big ? w_eb : w_ea;
      r_frc_s_p1 <= w_a_big ? w_fb : w_fa;
      r_diff_p1  <= w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
      r_sub_p1   <= w_sa ^ w_sb;
      r_nan_p1   <= w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sa ^ w_sb));
      r_inf_p1   <= w_inf_a | w_inf_b;
      r_vld_p1   <= r_vld_p0;
    end
  end

  // ---- Stage 2: align; shifted-out bits collapse into the sticky LSB
  logic [26:0] w_sig_l, w_sig_s, w_sh, w_lost;
  assign w_sig_l = {|r_exp_l_p1, r_frc_l_p1, 3'b000};
  assign w_sig_s = {|r_exp_s_p1, r_frc_s_p1, 3'b000};
  assign w_sh    = w_sig_s >> r_diff_p1;
  assign w_lost  = w_sig_s & ~({27{1'b1}} << r_diff_p1);

  logic        r_sgn_p2, r_sub_p2, r_nan_p2, r_inf_p2, r_vld_p2;
  logic [7:0]  r_exp_p2;
  logic [26:0] r_sig_l_p2, r_sig_s_p2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn_p2 <= 1'b0; r_sub_p2 <= 1'b0; r_nan_p2 <= 1'b0; r_inf_p2 <= 1'b0; r_vld_p2 <= 1'b0;
      r_exp_p2 <= '0; r_sig_l_p2 <= '0; r_sig_s_p2 <= '0;
    end else begin
      r_sgn_p2   <= r_sgn_p1;
      r_sub_p2   <= r_sub_p1;
      r_nan_p2   <= r_nan_p1;
      r_inf_p2   <= r_inf_p1;
      r_vld_p2   <= r_vld_p1;
      r_exp_p2   <= r_exp_l_p1;
      r_sig_l_p2 <= w_sig_l;
      r_sig_s_p2 <= {w_sh[26:1], w_sh[0] | (|w_lost)};
    end
  end

  // ---- Stage 3: execute; larger magnitude first, so subtraction never goes negative
  logic [27:0] w_sum;
  assign w_sum = r_sub_p2 ? ({1'b0, r_sig_l_p2} - {1'b0, r_sig_s_p2})
                          : ({1'b0, r_sig_l_p2} + {1'b0, r_sig_s_p2});

  logic        r_sgn_p3, r_nan_p3, r_inf_p3, r_vld_p3;
  logic [7:0]  r_exp_p3;
  logic [27:0] r_sum_p3;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn_p3 <= 1'b0; r_nan_p3 <= 1'b0; r_inf_p3 <= 1'b0; r_vld_p3 <= 1'b0;
      r_exp_p3 <= '0; r_sum_p3 <= '0;
    end else begin
      r_sgn_p3 <= r_sgn_p2; r_nan_p3 <= r_nan_p2; r_inf_p3 <= r_inf_p2; r_vld_p3 <= r_vld_p2;
      r_exp_p3 <= r_exp_p2; r_sum_p3 <= w_sum;
    end
  end

  // ---- Stage 4: normalize
  logic [4:0]         w_lz;
  logic signed [9:0]  w_e3, w_exp_n;
  logic [26:0]        w_man_n;
  assign w_lz = lzc27(r_sum_p3[26:0]);
  assign w_e3 = $signed({2'b00, r_exp_p3});
  always_comb begin
    w_man_n = r_sum_p3[26:0] << w_lz;
    w_exp_n = w_e3 - $signed({5'b00000, w_lz});
    if (r_sum_p3[27]) begin
      w_man_n = {r_sum_p3[27:2], r_sum_p3[1] | r_sum_p3[0]};
      w_exp_n = w_e3 + 10'sd1;
    end
  end

  logic               r_sgn_p4, r_zero_p4, r_nan_p4, r_inf_p4, r_vld_p4;
  logic signed [9:0]  r_exp_p4;
  logic [26:0]        r_man_p4;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn_p4 <= 1'b0; r_zero_p4 <= 1'b0; r_nan_p4 <= 1'b0; r_inf_p4 <= 1'b0; r_vld_p4 <= 1'b0;
      r_exp_p4 <= '0; r_man_p4 <= '0;
    end else begin
      r_sgn_p4 <= r_sgn_p3; r_nan_p4 <= r_nan_p3; r_inf_p4 <= r_inf_p3; r_vld_p4 <= r_vld_p3;
      r_zero_p4 <= (r_sum_p3 == 28'd0);
      r_exp_p4  <= w_exp_n;
      r_man_p4  <= w_man_n;
    end
  end

  // ---- Stage 5: round; a carry out of the significand renormalizes to 1.0
  logic [24:0] w_rnd;
  assign w_rnd = rne(r_man_p4);

  logic               r_sgn_p5, r_inex_p5, r_zero_p5, r_nan_p5, r_inf_p5, r_vld_p5;
  logic signed [9:0]  r_exp_p5;
  logic [22:0]        r_frc_p5;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn_p5 <= 1'b0; r_inex_p5 <= 1'b0; r_zero_p5 <= 1'b0; r_nan_p5 <= 1'b0;
      r_inf_p5 <= 1'b0; r_vld_p5 <= 1'b0; r_exp_p5 <= '0; r_frc_p5 <= '0;
    end else begin
      r_sgn_p5  <= r_sgn_p4; r_zero_p5 <= r_zero_p4; r_nan_p5 <= r_nan_p4;
      r_inf_p5  <= r_inf_p4; r_vld_p5  <= r_vld_p4;
      r_inex_p5 <= |r_man_p4[2:0];
      r_exp_p5  <= r_exp_p4 + $signed({9'd0, w_rnd[24]});
      r_frc_p5  <= w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
    end
  end

  // ---- Stage 6: exception resolution and output register
  logic [36:0] r_out_p6;
  always_ff @(posedge clk) begin
    if (rst) r_out_p6 <= '0;
    else     r_out_p6 <= resolve(r_vld_p5, r_nan_p5, r_inf_p5, r_zero_p5, r_sgn_p5,
                                 r_exp_p5, r_frc_p5, r_inex_p5);
  end

  assign Z      = r_out_p6[31:0];
  assign Flags  = r_out_p6[36:32];
  assign pipe_6 = r_out_p6;

`ifdef FPADDSUB_PIPE_DEBUG_EN
  assign pipe_0 = {r_ctrl_p0, r_b_p0, r_a_p0};
  assign pipe_1 = {26'd0, r_vld_p1, r_inf_p1, r_nan_p1, r_sub_p1, r_diff_p1, r_frc_s_p1,
                   r_exp_s_p1, r_frc_l_p1, r_exp_l_p1, r_sgn_p1};
  assign pipe_2 = {29'd0, r_vld_p2, r_inf_p2, r_nan_p2, r_sub_p2, r_sig_s_p2, r_sig_l_p2,
                   r_exp_p2, r_sgn_p2};
  assign pipe_3 = {36'd0, r_vld_p3, r_inf_p3, r_nan_p3, r_sum_p3, r_exp_p3, r_sgn_p3};
  assign pipe_4 = {33'd0, r_vld_p4, r_inf_p4, r_nan_p4, r_zero_p4, r_man_p4, r_exp_p4, r_sgn_p4};
  assign pipe_5 = {33'd0, r_vld_p5, r_inf_p5, r_nan_p5, r_zero_p5, r_inex_p5, r_frc_p5,
                   r_exp_p5, r_sgn_p5};
`else
  assign pipe_0 = '0;
  assign pipe_1 = '0;
  assign pipe_2 = '0;
  assign pipe_3 = '0;
  assign pipe_4 = '0;
  assign pipe_5 = '0;
`endif

endmodule

// File: tb/tb_fp_add_sub.sv
// Bench for fp_add_sub: directed vector table, randomized stream against an exact-arithmetic model,
// fixed-latency check and a mid-stream reset flush.
module tb_fp_add_sub;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  A, B, Z;
  logic [2:0]   Ctrl;
  logic [4:0]   Flags;
  logic [66:0]  pipe_0;
  logic [100:0] pipe_1;
  logic [95:0]  pipe_2;
  logic [75:0]  pipe_3;
  logic [74:0]  pipe_4;
  logic [71:0]  pipe_5;
  logic [36:0]  pipe_6;

  fp_add_sub dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Ctrl(Ctrl), .Z(Z), .Flags(Flags),
    .pipe_0(pipe_0), .pipe_1(pipe_1), .pipe_2(pipe_2), .pipe_3(pipe_3),
    .pipe_4(pipe_4), .pipe_5(pipe_5), .pipe_6(pipe_6)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [31:0] z;
    logic [4:0]  f;
  } vec_t;

  logic [31:0] sa_v [0:255];
  logic [31:0] sb_v [0:255];
  logic [2:0]  sc_v [0:255];
  logic [31:0] ez_v [0:255];
  logic [4:0]  ef_v [0:255];

  // Exact reference: operands become integers scaled by 2^-149, summed without loss, then rounded.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic sa, sb, sg, g, st, na, nb, ia, ib;
    int ea, eb, m, e;
    logic [299:0] va, vb, s, kv;
    longint k;
    sa = a[31];
    sb = b[31] ^ c[0];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    if (na || nb || (ia && ib && (sa != sb))) return {5'b10000, 32'h7FC00000};
    if (ia) return {5'b00000, sa, 8'hFF, 23'd0};
    if (ib) return {5'b00000, sb, 8'hFF, 23'd0};
    va = (ea == 0) ? 300'd0 : (300'({1'b1, a[22:0]}) << (ea - 1));
    vb = (eb == 0) ? 300'd0 : (300'({1'b1, b[22:0]}) << (eb - 1));
    if (sa == sb)      begin s = va + vb; sg = sa; end
    else if (va >= vb) begin s = va - vb; sg = sa; end
    else               begin s = vb - va; sg = sb; end
    if (s == 0) return {5'b00001, 32'd0};
    m = 0;
    for (int i = 0; i < 300; i++) if (s[i]) m = i;
    g = 1'b0;
    st = 1'b0;
    if (m >= 23) begin
      kv = s >> (m - 23);
      k = longint'(kv[23:0]);
      if (m >= 24) begin
        g  = s[m - 24];
        st = (s & ((300'd1 << (m - 24)) - 300'd1)) != 0;
      end
    end else begin
      k = longint'(s[23:0]) << (23 - m);
    end
    if (g && (st || k[0])) k = k + 1;
    e = m - 22;
    if (k == (longint'(1) << 24)) begin k = k >> 1; e = e + 1; end
    if (e >= 255) return {5'b01010, sg, 8'hFF, 23'd0};
    if (e <= 0)   return {5'b00111, sg, 31'd0};
    return {3'b000, g | st, 1'b0, sg, 8'(e), k[22:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] z_exp, input logic [4:0] f_exp);
    total++;
    if (Z !== z_exp || Flags !== f_exp) begin
      bad++;
      $display("FAIL %s: Z=%08h Flags=%05b, expected Z=%08h Flags=%05b", nm, Z, Flags, z_exp, f_exp);
    end
  endtask

  task automatic check_bus(input string nm, input logic [100:0] v);
    total++;
    if (v !== 101'd0) begin
      bad++;
      $display("FAIL %s: value=%h, expected 0", nm, v);
    end
  endtask

  task automatic gen_rand(input int idx);
    logic [31:0] a, b;
    logic [36:0] r;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1, 2: b[30:23] = a[30:23] ^ 8'($urandom_range(0, 3));
      3: begin
        a[30:23] = 8'($urandom_range(250, 254));
        b[30:23] = 8'($urandom_range(250, 254));
      end
      4: begin
        a[30:23] = 8'($urandom_range(1, 4));
        b[30:23] = a[30:23];
        b[22:0]  = a[22:0] ^ 23'($urandom_range(0, 15));
      end
      default: b = a ^ 32'h8000_0000;
    endcase
    sa_v[idx] = a;
    sb_v[idx] = b;
    sc_v[idx] = 3'($urandom_range(0, 7));
    r = model(a, b, sc_v[idx]);
    ez_v[idx] = r[31:0];
    ef_v[idx] = r[36:32];
  endtask

  // One operand per cycle; the result of the operand captured at edge t is checked after edge t+6.
  task automatic run_stream(input int n, input string tag);
    for (int t = 0; t < n + 6; t++) begin
      if (t < n) begin
        A = sa_v[t]; B = sb_v[t]; Ctrl = sc_v[t];
      end
      @(posedge clk); #1;
      if (t >= 6) check($sformatf("%s[%0d]", tag, t - 6), ez_v[t - 6], ef_v[t - 6]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tv [16];
    tv[0]  = '{32'h3F800000, 32'h3F800000, 3'b000, 32'h40000000, 5'b00000};
    tv[1]  = '{32'h3FC00000, 32'hBF800000, 3'b000, 32'h3F000000, 5'b00000};
    tv[2]  = '{32'h40A00000, 32'h40C00000, 3'b001, 32'hBF800000, 5'b00000};
    tv[3]  = '{32'h445013F8, 32'h41B8CCCD, 3'b111, 32'h444A4D92, 5'b00010};
    tv[4]  = '{32'hC39D8000, 32'hC2110106, 3'b110, 32'hC3AFA021, 5'b00010};
    tv[5]  = '{32'h3FC00000, 32'h3FC00000, 3'b001, 32'h00000000, 5'b00001};
    tv[6]  = '{32'h3DCCCCCD, 32'h00000000, 3'b000, 32'h3DCCCCCD, 5'b00000};
    tv[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 32'h7F800000, 5'b01010};
    tv[8]  = '{32'h7F800000, 32'h7F800000, 3'b001, 32'h7FC00000, 5'b10000};
    tv[9]  = '{32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b10000};
    tv[10] = '{32'hFF800000, 32'h3F800000, 3'b000, 32'hFF800000, 5'b00000};
    tv[11] = '{32'h00800000, 32'h00800001, 3'b001, 32'h80000000, 5'b00111};
    tv[12] = '{32'h00000001, 32'h3F800000, 3'b000, 32'h3F800000, 5'b00000};
    tv[13] = '{32'h3F800001, 32'h33800000, 3'b000, 32'h3F800002, 5'b00010};
    tv[14] = '{32'h3F800000, 32'h33800000, 3'b000, 32'h3F800000, 5'b00010};
    tv[15] = '{32'h00000000, 32'h00000000, 3'b000, 32'h00000000, 5'b00001};

    rst = 1'b1; A = '0; B = '0; Ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'd0, 5'd0);
    check_bus("reset_pipe0", 101'(pipe_0));
    check_bus("reset_pipe3", 101'(pipe_3));
    check_bus("reset_pipe5", 101'(pipe_5));
    check_bus("reset_pipe6", 101'(pipe_6));

    // Release reset and present the first operand in the same cycle.
    rst = 1'b0;
    A = 32'h3F800000; B = 32'h3F800000; Ctrl = 3'b000;
    @(posedge clk); #1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) check("latency_early", 32'd0, 5'd0);
      if (k == 6) check("latency_exact", 32'h40000000, 5'd0);
    end

    for (int i = 0; i < 16; i++) begin
      sa_v[i] = tv[i].a; sb_v[i] = tv[i].b; sc_v[i] = tv[i].c;
      ez_v[i] = tv[i].z; ef_v[i] = tv[i].f;
    end
    run_stream(16, "vec");

    for (int i = 0; i < 200; i++) gen_rand(i);
    run_stream(200, "rnd");

    // Mid-stream reset: six operands in flight are dropped, the next six come through.
    for (int i = 0; i < 12; i++) gen_rand(i);
    for (int t = 0; t < 6; t++) begin
      A = sa_v[t]; B = sb_v[t]; Ctrl = sc_v[t];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    A = sa_v[6]; B = sb_v[6]; Ctrl = sc_v[6];
    @(posedge clk); #1;
    check("rst_edge", 32'd0, 5'd0);
    rst = 1'b0;
    for (int t = 6; t < 12; t++) begin
      A = sa_v[t]; B = sb_v[t]; Ctrl = sc_v[t];
      @(posedge clk); #1;
      check($sformatf("flush[%0d]", t - 6), 32'd0, 5'd0);
    end
    for (int t = 6; t < 12; t++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst[%0d]", t), ez_v[t], ef_v[t]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
